// File: rtl/wb_buf_stage.sv
// Writeback stage with a DEPTH-entry in-order retire buffer feeding the RF port.
// Optional byte-merged forwarding lookup is built when WB_BUF_FWD_EN is defined.
module wb_buf_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_allowin,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic                       in_gr_we,
    input  logic [DATA_W/8-1:0]        in_wen,
    input  logic [ADDR_W-1:0]          in_dest,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       ws_stall,
    output logic [DATA_W/8-1:0]        rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic                       ws_reg_write,
    input  logic [ADDR_W-1:0]          fwd_raddr1,
    input  logic [ADDR_W-1:0]          fwd_raddr2,
    output logic [DATA_W/8-1:0]        fwd_bmask1,
    output logic [DATA_W/8-1:0]        fwd_bmask2,
    output logic [DATA_W-1:0]          fwd_data1,
    output logic [DATA_W-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [DATA_W-1:0]          debug_wb_pc,
    output logic [DATA_W/8-1:0]        debug_wb_rf_wen,
    output logic [ADDR_W-1:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]          debug_wb_rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DATA_W / 8;

    logic [DATA_W-1:0] r_pc   [DEPTH];
    logic              r_we   [DEPTH];
    logic [BW-1:0]     r_wen  [DEPTH];
    logic [ADDR_W-1:0] r_dest [DEPTH];
    logic [DATA_W-1:0] r_res  [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_retire;
    logic w_enq;

    assign w_retire   = (r_count != '0) && !ws_stall;
    assign in_allowin = (r_count < CW'(DEPTH)) || w_retire;
    assign w_enq      = in_valid && in_allowin;
    assign occupancy  = r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + PW'(1);
            if (w_retire)
                r_head <= r_head + PW'(1);
            if (w_enq && !w_retire)
                r_count <= r_count + CW'(1);
            else if (!w_enq && w_retire)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_tail]   <= in_pc;
            r_we[r_tail]   <= in_gr_we;
            r_wen[r_tail]  <= in_wen;
            r_dest[r_tail] <= in_dest;
            r_res[r_tail]  <= in_result;
        end
    end

    always_comb begin
        rf_we       = '0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        debug_wb_pc = '0;
        if (w_retire) begin
            rf_we       = r_we[r_head] ? r_wen[r_head] : '0;
            rf_waddr    = r_dest[r_head];
            rf_wdata    = r_res[r_head];
            debug_wb_pc = r_pc[r_head];
        end
    end

    assign ws_reg_write      = (rf_we != '0);
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_BUF_FWD_EN
    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so a younger hit overrides each byte it enables.
    always_comb begin
        fwd_bmask1 = '0;
        fwd_bmask2 = '0;
        fwd_data1  = '0;
        fwd_data2  = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && r_we[w_idx]) begin
                for (int unsigned b = 0; b < BW; b++) begin
                    if (r_wen[w_idx][b]) begin
                        if (fwd_raddr1 != '0 && r_dest[w_idx] == fwd_raddr1) begin
                            fwd_bmask1[b]       = 1'b1;
                            fwd_data1[8*b +: 8] = r_res[w_idx][8*b +: 8];
                        end
                        if (fwd_raddr2 != '0 && r_dest[w_idx] == fwd_raddr2) begin
                            fwd_bmask2[b]       = 1'b1;
                            fwd_data2[8*b +: 8] = r_res[w_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
    end
`else
    logic w_unused_raddr;
    assign w_unused_raddr = ^{fwd_raddr1, fwd_raddr2};
    assign fwd_bmask1     = '0;
    assign fwd_bmask2     = '0;
    assign fwd_data1      = '0;
    assign fwd_data2      = '0;
`endif

endmodule

// File: tb/tb_wb_buf_stage.sv
// Directed self-checking bench for wb_buf_stage (DEPTH=2); forwarding
// expectations follow whether WB_BUF_FWD_EN is defined for the build.
module tb_wb_buf_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_allowin;
    logic [31:0] in_pc;
    logic        in_gr_we;
    logic [3:0]  in_wen;
    logic [4:0]  in_dest;
    logic [31:0] in_result;
    logic        ws_stall;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_reg_write;
    logic [4:0]  fwd_raddr1, fwd_raddr2;
    logic [3:0]  fwd_bmask1, fwd_bmask2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [1:0]  occupancy;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

`ifdef WB_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_buf_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_pc(in_pc),
        .in_gr_we(in_gr_we), .in_wen(in_wen), .in_dest(in_dest), .in_result(in_result),
        .ws_stall(ws_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_reg_write(ws_reg_write),
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_bmask1(fwd_bmask1), .fwd_bmask2(fwd_bmask2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .occupancy(occupancy),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                         input logic [3:0] wen, input logic [4:0] dest, input logic [31:0] res);
        in_valid = v; in_pc = pc; in_gr_we = we; in_wen = wen; in_dest = dest; in_result = res;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ws_stall = 1'b0; fwd_raddr1 = 5'd0; fwd_raddr2 = 5'd0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        #12;
        total++; if (in_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b exp=1", in_allowin); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if ({rf_we, rf_waddr, rf_wdata, ws_reg_write} !== '0) begin bad++; $display("FAIL reset_rf got=%h/%h/%h exp=0", rf_we, rf_waddr, rf_wdata); end
        total++; if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) begin bad++; $display("FAIL reset_debug got pc=%h exp=0", debug_wb_pc); end
        total++; if ({fwd_bmask1, fwd_bmask2, fwd_data1, fwd_data2} !== '0) begin bad++; $display("FAIL reset_fwd got=%h/%h exp=0", fwd_bmask1, fwd_data1); end
        @(negedge clk); resetn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'hbfc00000, 1'b1, 4'hF, 5'd3, 32'h11);
        tick();
        drive(1'b1, 32'hbfc00004, 1'b1, 4'hF, 5'd4, 32'h22);
        #1;
        total++; if (rf_we !== 4'hF || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin bad++; $display("FAIL b2b_first got we=%h a=%0d d=%h exp we=f a=3 d=11", rf_we, rf_waddr, rf_wdata); end
        total++; if (debug_wb_pc !== 32'hbfc00000 || ws_reg_write !== 1'b1) begin bad++; $display("FAIL b2b_trace got pc=%h rw=%b exp pc=bfc00000 rw=1", debug_wb_pc, ws_reg_write); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL b2b_occ1 got=%0d exp=1", occupancy); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        total++; if (rf_we !== 4'hF || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin bad++; $display("FAIL b2b_second got we=%h a=%0d d=%h exp we=f a=4 d=22", rf_we, rf_waddr, rf_wdata); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL b2b_occ2 got=%0d exp=1", occupancy); end
        tick();
        total++; if (occupancy !== 2'd0 || rf_we !== 4'h0) begin bad++; $display("FAIL b2b_drain got occ=%0d we=%h exp occ=0 we=0", occupancy, rf_we); end
    endtask

    task automatic test_stall_fill();
        ws_stall = 1'b1;
        drive(1'b1, 32'h600, 1'b1, 4'hF, 5'd6, 32'h60);
        #1;
        total++; if (in_allowin !== 1'b1) begin bad++; $display("FAIL fill_allow0 got=%b exp=1", in_allowin); end
        tick();
        drive(1'b1, 32'h700, 1'b1, 4'hF, 5'd7, 32'h70);
        tick();
        drive(1'b1, 32'h800, 1'b1, 4'hF, 5'd8, 32'h80);
        #1;
        total++; if (in_allowin !== 1'b0 || occupancy !== 2'd2) begin bad++; $display("FAIL fill_full got allow=%b occ=%0d exp allow=0 occ=2", in_allowin, occupancy); end
        total++; if (rf_we !== 4'h0 || debug_wb_pc !== 32'h0) begin bad++; $display("FAIL fill_stalled_rf got we=%h pc=%h exp 0", rf_we, debug_wb_pc); end
        tick();
        total++; if (occupancy !== 2'd2 || rf_we !== 4'h0) begin bad++; $display("FAIL fill_hold got occ=%0d we=%h exp occ=2 we=0", occupancy, rf_we); end
        ws_stall = 1'b0;
        #1;
        total++; if (in_allowin !== 1'b1 || rf_we !== 4'hF || rf_waddr !== 5'd6 || rf_wdata !== 32'h60) begin bad++; $display("FAIL fill_first got allow=%b a=%0d d=%h exp allow=1 a=6 d=60", in_allowin, rf_waddr, rf_wdata); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        total++; if (occupancy !== 2'd2 || rf_waddr !== 5'd7 || rf_we !== 4'hF) begin bad++; $display("FAIL fill_second got occ=%0d a=%0d exp occ=2 a=7", occupancy, rf_waddr); end
        tick();
        total++; if (occupancy !== 2'd1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h80 || debug_wb_pc !== 32'h800) begin bad++; $display("FAIL fill_third got occ=%0d a=%0d d=%h exp occ=1 a=8 d=80", occupancy, rf_waddr, rf_wdata); end
        tick();
        total++; if (occupancy !== 2'd0 || rf_we !== 4'h0) begin bad++; $display("FAIL fill_drain got occ=%0d we=%h exp 0", occupancy, rf_we); end
    endtask

    task automatic test_byte_merge();
        ws_stall = 1'b1;
        drive(1'b1, 32'h900, 1'b1, 4'hF, 5'd5, 32'hAABBCCDD);
        tick();
        drive(1'b1, 32'h904, 1'b1, 4'h3, 5'd5, 32'h00001122);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        fwd_raddr1 = 5'd5; fwd_raddr2 = 5'd3;
        #1;
        total++; if (fwd_bmask1 !== (FWD ? 4'hF : 4'h0) || fwd_data1 !== (FWD ? 32'hAABB1122 : 32'h0)) begin bad++; $display("FAIL merge_port1 got m=%h d=%h exp m=%h d=%h", fwd_bmask1, fwd_data1, FWD ? 4'hF : 4'h0, FWD ? 32'hAABB1122 : 32'h0); end
        total++; if (fwd_bmask2 !== 4'h0 || fwd_data2 !== 32'h0) begin bad++; $display("FAIL merge_port2_miss got m=%h d=%h exp 0", fwd_bmask2, fwd_data2); end
        fwd_raddr2 = 5'd5;
        ws_stall = 1'b0;
        #1;
        total++; if (fwd_bmask2 !== (FWD ? 4'hF : 4'h0) || fwd_data2 !== (FWD ? 32'hAABB1122 : 32'h0)) begin bad++; $display("FAIL merge_port2_retiring got m=%h d=%h", fwd_bmask2, fwd_data2); end
        total++; if (rf_we !== 4'hF || rf_waddr !== 5'd5 || rf_wdata !== 32'hAABBCCDD) begin bad++; $display("FAIL merge_rf_old got we=%h d=%h exp we=f d=aabbccdd", rf_we, rf_wdata); end
        tick();
        total++; if (rf_we !== 4'h3 || rf_wdata !== 32'h00001122) begin bad++; $display("FAIL merge_rf_young got we=%h d=%h exp we=3 d=1122", rf_we, rf_wdata); end
        total++; if (fwd_bmask1 !== (FWD ? 4'h3 : 4'h0) || fwd_data1 !== (FWD ? 32'h00001122 : 32'h0)) begin bad++; $display("FAIL merge_after got m=%h d=%h", fwd_bmask1, fwd_data1); end
        tick();
        total++; if (fwd_bmask1 !== 4'h0 || fwd_data1 !== 32'h0 || occupancy !== 2'd0) begin bad++; $display("FAIL merge_empty got m=%h d=%h occ=%0d exp 0", fwd_bmask1, fwd_data1, occupancy); end
    endtask

    task automatic test_zero_nowrite();
        ws_stall = 1'b1;
        drive(1'b1, 32'h200, 1'b1, 4'hF, 5'd0, 32'h55);
        tick();
        drive(1'b1, 32'h100, 1'b0, 4'hF, 5'd9, 32'h99);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        fwd_raddr1 = 5'd0; fwd_raddr2 = 5'd9;
        #1;
        total++; if (fwd_bmask1 !== 4'h0 || fwd_data1 !== 32'h0) begin bad++; $display("FAIL zero_raddr got m=%h d=%h exp 0", fwd_bmask1, fwd_data1); end
        total++; if (fwd_bmask2 !== 4'h0) begin bad++; $display("FAIL nowrite_fwd got m=%h exp 0", fwd_bmask2); end
        ws_stall = 1'b0;
        #1;
        total++; if (debug_wb_pc !== 32'h200 || rf_we !== 4'hF || rf_waddr !== 5'd0) begin bad++; $display("FAIL zero_retire got pc=%h we=%h exp pc=200 we=f", debug_wb_pc, rf_we); end
        tick();
        total++; if (debug_wb_pc !== 32'h100 || debug_wb_rf_wen !== 4'h0 || ws_reg_write !== 1'b0) begin bad++; $display("FAIL nowrite_trace got pc=%h wen=%h rw=%b exp pc=100 wen=0 rw=0", debug_wb_pc, debug_wb_rf_wen, ws_reg_write); end
        tick();
    endtask

    task automatic test_reset_mid();
        ws_stall = 1'b1;
        drive(1'b1, 32'hA00, 1'b1, 4'hF, 5'd10, 32'hA0);
        tick();
        drive(1'b1, 32'hB00, 1'b1, 4'hF, 5'd11, 32'hB0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0, 32'h0);
        #1;
        total++; if (occupancy !== 2'd2 || in_allowin !== 1'b0) begin bad++; $display("FAIL rst_pre got occ=%0d allow=%b exp occ=2 allow=0", occupancy, in_allowin); end
        #1 resetn = 1'b0;
        #1;
        total++; if (occupancy !== 2'd0 || in_allowin !== 1'b1) begin bad++; $display("FAIL rst_async got occ=%0d allow=%b exp occ=0 allow=1", occupancy, in_allowin); end
        @(negedge clk); resetn = 1'b1; ws_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rf_we !== 4'h0 || occupancy !== 2'd0) begin bad++; $display("FAIL rst_nowrite got we=%h occ=%0d exp 0", rf_we, occupancy); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_fill();
        test_byte_merge();
        test_zero_nowrite();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_buf_stage.md
# wb_buf_stage

Parametrised writeback stage with a DEPTH-entry in-order retire buffer that sits between the M2S stage and the register file. It accepts one result per cycle and retires the oldest entry to the RF write port only on non-stalled cycles, so every result is written exactly once. It decouples upstream flow from hazard stalls until the buffer is full. It also provides byte-merged forwarding lookup for two read ports over all buffered results.

## Interface
- DATA_W, 32, result/PC width
- ADDR_W, 5, register address width
- DEPTH, 2, buffer entries; power of two, ≥2
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream result valid
- in_allowin  out  1  buffer can accept this cycle
- in_pc  in  DATA_W  instruction PC
- in_gr_we  in  1  GPR write intent
- in_wen  in  DATA_W/8  byte write enables
- in_dest  in  ADDR_W  destination register
- in_result  in  DATA_W  final result
- ws_stall  in  1  hazard unit blocks retirement
- rf_we  out  DATA_W/8  RF byte write enables (retire cycle only)
- rf_waddr  out  ADDR_W  RF write address
- rf_wdata  out  DATA_W  RF write data
- ws_reg_write  out  1  rf_we != 0
- fwd_raddr1, fwd_raddr2  in  ADDR_W  lookup addresses
- fwd_bmask1, fwd_bmask2  out  DATA_W/8  per-byte hit
- fwd_data1, fwd_data2  out  DATA_W  merged forwarding data
- occupancy  out  clog2(DEPTH)+1  valid entries
- debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata  out  DATA_W/4/ADDR_W/DATA_W  trace

## Operation
- Circular buffer with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- retire = (count != 0) && !ws_stall. Head entry leaves the buffer at the clock edge.
- in_allowin = (count < DEPTH) || retire. This is combinational from count and ws_stall.
- Enqueue when in_valid && in_allowin: the entry is written at tail and tail advances.
- Entries with in_gr_we=0 or in_wen=0 are still buffered and retired, so their PC reaches trace.
- RF write signals on the retire cycle:
  - rf_we = {gr_we}&wen of the head entry.
  - rf_waddr = head dest; rf_wdata = head result.
- When not retiring, rf_we=0 and waddr/wdata=0.
- Debug trace signals mirror the RF port. debug_wb_pc = head pc on the retire cycle, else 0.
- Simultaneous enqueue and retire: count unchanged. This holds when full as well (a full buffer accepts while retiring).
- Forwarding, per port:
  - Candidates are valid entries with gr_we=1, dest==raddr and raddr!=0. The retiring head is included.
  - For each byte, the youngest candidate with that byte enabled supplies the data and sets the bmask bit.
  - Bytes with no candidate return bmask=0 and data=0.
  - Lookup is combinational from buffer state, and a newly enqueued entry is visible from the following cycle.
- Async reset clears count and pointers and discards all pending writes. Entry payload need not be reset.

## Timing
- Reset values:
  - in_allowin=1; occupancy=0.
  - All rf_*, ws_reg_write, debug_*, fwd_bmask* and fwd_data* are 0.
- Latency from enqueue edge to RF write is 1 cycle when the buffer is empty and ws_stall=0.
- A stalled head holds its outputs at 0. It writes on the first cycle with ws_stall=0 and never writes twice.
- Throughput is 1 entry/cycle sustained with no stall.
- With ws_stall held, the buffer fills in DEPTH accepted cycles. in_allowin then falls combinationally.

## Configuration
- WB_BUF_FWD_EN:
  - Defined: the lookup logic is built.
  - Undefined: no lookup logic; fwd_bmask* and fwd_data* are tied to 0, fwd_raddr* are ignored, and all other behaviour is identical.

## Test plan
- Back-to-back, no stall, DEPTH=2:
  - Stimulus: enqueue (pc 0xbfc00000, dest 3, result 0x11, wen 0xF), then (dest 4, result 0x22).
  - Required: rf_we=0xF with waddr 3 on cycle+1 and waddr 4 on cycle+2; occupancy never exceeds 1.
- Stall fill:
  - Stimulus: hold ws_stall, offer 3 entries.
  - Required: 2 accepted and in_allowin=0 with occupancy=2. The third is accepted on the first unstalled cycle with occupancy staying 2. All three write once, in order.
- Byte merge:
  - Stimulus: buffer holds older dest 5 result 0xAABBCCDD wen 0xF, and younger dest 5 result 0x00001122 wen 0x3. Set fwd_raddr1=5.
  - Required: bmask1=0xF, data1=0xAABB1122.
- Zero register and no-write entries:
  - Stimulus: dest 0, then gr_we=0 entry with pc 0x100; lookup raddr 0.
  - Required: bmask=0. The pc 0x100 retire gives debug_wb_pc=0x100 with debug_wb_rf_wen=0.
- Reset mid-operation:
  - Stimulus: occupancy=2, stalled; assert resetn=0 asynchronously between edges.
  - Required: occupancy=0, in_allowin=1 immediately. No RF write occurs after release.
- Macro off:
  - Stimulus: rebuild without WB_BUF_FWD_EN; rerun the byte-merge case.
  - Required: bmask1=0, data1=0; RF writes unchanged.
